// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants and state encoding for the JPEG entropy front end
// Contents: BLOCK_LEN (coefficients per 8x8 block), COEF_W (coefficient width),
//           ZRL_RUN (run value of the zero-run-length symbol), sched_state_t.
package jpeg_pkg;

  localparam int         BLOCK_LEN = 64;
  localparam int         COEF_W    = 11;
  localparam logic [3:0] ZRL_RUN   = 4'd15;

  typedef enum logic [2:0] {
    S_DC    = 3'd0,
    S_AC    = 3'd1,
    S_ZRL   = 3'd2,
    S_SYM   = 3'd3,
    S_EOB   = 3'd4,
    S_FLUSH = 3'd5
  } sched_state_t;

endpackage

// File: rtl/ones_encoder.sv
// rtl/ones_encoder.sv - magnitude category and ones-complement value bits of a signed coefficient
// Ports: value (in, WIDTH, two's complement, never the most negative code)
//        size  (out, 4, bit length of |value|)
//        bits  (out, WIDTH-1, value if positive else value-1, masked to size bits)
module ones_encoder #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] value,
  output logic [3:0]       size,
  output logic [WIDTH-2:0] bits
);

  logic [WIDTH-2:0] mag;
  logic [WIDTH-2:0] mask;

  always_comb begin
    mag = (WIDTH-1)'(value[WIDTH-1] ? (~value + WIDTH'(1)) : value);
    size = 4'd0;
    // Highest set bit wins, giving the bit length.
    for (int i = 0; i < WIDTH-1; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    mask = '0;
    for (int i = 0; i < WIDTH-1; i++) begin
      mask[i] = (i < int'(size));
    end
    bits = value[WIDTH-1] ? ((WIDTH-1)'(value - WIDTH'(1)) & mask) : value[WIDTH-2:0];
  end

endmodule

// File: rtl/rle_scheduler.sv
// rtl/rle_scheduler.sv - zigzag coefficient run-length scheduler feeding a Huffman coder
// Ports: clk, rst (sync, active-high)
//        coefficient in : ena_in, rdy_out, coef[10:0], last_block (sampled with coefficient 0)
//        symbol out     : ena_out, rdy_in, dc, in_dc[10:0], run[3:0], size[3:0], in[9:0]
//        status pulses  : block_done (after final symbol of a block), flush (end of image)
module rle_scheduler
  import jpeg_pkg::*;
#(
  parameter int BLOCK_LEN = jpeg_pkg::BLOCK_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena_in,
  output logic        rdy_out,
  input  logic [10:0] coef,
  input  logic        last_block,
  output logic        ena_out,
  input  logic        rdy_in,
  output logic        dc,
  output logic [10:0] in_dc,
  output logic [3:0]  run,
  output logic [3:0]  size,
  output logic [9:0]  in,
  output logic        flush,
  output logic        block_done
);

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_LEN - 1);

  sched_state_t state, state_nxt;
  logic [5:0]   idx, idx_nxt, zrun, zrun_nxt, zrun_less;
  logic         last_q, last_nxt, sym_last, sym_last_nxt;
  logic [3:0]   lat_size, lat_size_nxt, enc_size;
  logic [9:0]   lat_bits, lat_bits_nxt, enc_bits;
  logic         ena_out_nxt, dc_nxt, flush_nxt, block_done_nxt;
  logic [10:0]  in_dc_nxt;
  logic [3:0]   run_nxt, size_nxt;
  logic [9:0]   in_nxt;
  logic         accept, xfer;

  ones_encoder #(.WIDTH(COEF_W)) u_enc (
    .value (coef),
    .size  (enc_size),
    .bits  (enc_bits)
  );

  assign rdy_out   = ((state == S_DC) || (state == S_AC)) && !ena_out;
  assign accept    = ena_in && rdy_out;
  assign xfer      = ena_out && rdy_in;
  assign zrun_less = zrun - 6'd16;

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    zrun_nxt       = zrun;
    last_nxt       = last_q;
    sym_last_nxt   = sym_last;
    lat_size_nxt   = lat_size;
    lat_bits_nxt   = lat_bits;
    ena_out_nxt    = ena_out;
    dc_nxt         = dc;
    in_dc_nxt      = in_dc;
    run_nxt        = run;
    size_nxt       = size;
    in_nxt         = in;
    flush_nxt      = 1'b0;
    block_done_nxt = 1'b0;
    unique case (state)
      S_DC: begin
        if (accept) begin
          in_dc_nxt   = coef;
          last_nxt    = last_block;
          idx_nxt     = 6'd1;
          zrun_nxt    = 6'd0;
          dc_nxt      = 1'b1;
          ena_out_nxt = 1'b1;
          run_nxt     = 4'd0;
          size_nxt    = 4'd0;
          in_nxt      = 10'd0;
          state_nxt   = S_AC;
        end
      end
      S_AC: begin
        // Only the DC symbol can be pending here; accept is blocked while it is.
        if (xfer) begin
          ena_out_nxt = 1'b0;
          dc_nxt      = 1'b0;
        end else if (accept) begin
          if (coef == '0) begin
            if (idx == LAST_IDX) begin
              // Trailing zeros collapse into EOB; outstanding ZRLs are dropped.
              zrun_nxt    = 6'd0;
              ena_out_nxt = 1'b1;
              run_nxt     = 4'd0;
              size_nxt    = 4'd0;
              in_nxt      = 10'd0;
              state_nxt   = S_EOB;
            end else begin
              zrun_nxt = zrun + 6'd1;
              idx_nxt  = idx + 6'd1;
            end
          end else begin
            lat_size_nxt = enc_size;
            lat_bits_nxt = enc_bits;
            sym_last_nxt = (idx == LAST_IDX);
            idx_nxt      = idx + 6'd1;
            ena_out_nxt  = 1'b1;
            if (zrun >= 6'd16) begin
              run_nxt   = ZRL_RUN;
              size_nxt  = 4'd0;
              in_nxt    = 10'd0;
              state_nxt = S_ZRL;
            end else begin
              run_nxt   = zrun[3:0];
              size_nxt  = enc_size;
              in_nxt    = enc_bits;
              state_nxt = S_SYM;
            end
          end
        end
      end
      S_ZRL: begin
        if (xfer) begin
          zrun_nxt = zrun_less;
          if (zrun_less < 6'd16) begin
            run_nxt   = zrun_less[3:0];
            size_nxt  = lat_size;
            in_nxt    = lat_bits;
            state_nxt = S_SYM;
          end
        end
      end
      S_SYM: begin
        if (xfer) begin
          zrun_nxt    = 6'd0;
          ena_out_nxt = 1'b0;
          if (sym_last) begin
            block_done_nxt = 1'b1;
            state_nxt      = last_q ? S_FLUSH : S_DC;
          end else begin
            state_nxt = S_AC;
          end
        end
      end
      S_EOB: begin
        if (xfer) begin
          ena_out_nxt    = 1'b0;
          block_done_nxt = 1'b1;
          state_nxt      = last_q ? S_FLUSH : S_DC;
        end
      end
      S_FLUSH: begin
        if (rdy_in) begin
          flush_nxt = 1'b1;
          state_nxt = S_DC;
        end
      end
      default: state_nxt = S_DC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_DC;
      idx        <= 6'd0;
      zrun       <= 6'd0;
      last_q     <= 1'b0;
      sym_last   <= 1'b0;
      lat_size   <= 4'd0;
      lat_bits   <= 10'd0;
      ena_out    <= 1'b0;
      dc         <= 1'b0;
      in_dc      <= 11'd0;
      run        <= 4'd0;
      size       <= 4'd0;
      in         <= 10'd0;
      flush      <= 1'b0;
      block_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      zrun       <= zrun_nxt;
      last_q     <= last_nxt;
      sym_last   <= sym_last_nxt;
      lat_size   <= lat_size_nxt;
      lat_bits   <= lat_bits_nxt;
      ena_out    <= ena_out_nxt;
      dc         <= dc_nxt;
      in_dc      <= in_dc_nxt;
      run        <= run_nxt;
      size       <= size_nxt;
      in         <= in_nxt;
      flush      <= flush_nxt;
      block_done <= block_done_nxt;
    end
  end

endmodule

// File: tb/tb_rle_scheduler.sv
// tb/tb_rle_scheduler.sv - self-checking bench for rle_scheduler against a block-level symbol model
module tb_rle_scheduler;

  logic        clk = 1'b0;
  logic        rst, ena_in, rdy_out, last_block, ena_out, rdy_in, dc, flush, block_done;
  logic [10:0] coef, in_dc;
  logic [3:0]  run, size;
  logic [9:0]  in;

  int vectors = 0;
  int miscompares = 0;
  int blk[64];
  logic [29:0] exp_q[$];

  always #5 clk = ~clk;

  rle_scheduler #(.BLOCK_LEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena_in     (ena_in),
    .rdy_out    (rdy_out),
    .coef       (coef),
    .last_block (last_block),
    .ena_out    (ena_out),
    .rdy_in     (rdy_in),
    .dc         (dc),
    .in_dc      (in_dc),
    .run        (run),
    .size       (size),
    .in         (in),
    .flush      (flush),
    .block_done (block_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] sym(input bit is_dc, input int dcv, input int r, input int s, input int v);
    if (is_dc) return {1'b1, 11'(dcv), 18'd0};
    return {1'b0, 11'd0, 4'(r), 4'(s), 10'(v)};
  endfunction

  function automatic logic [29:0] obs_sym();
    if (dc) return {1'b1, in_dc, 18'd0};
    return {1'b0, 11'd0, run, size, in};
  endfunction

  // JPEG run-length rules applied to the whole block at once.
  function automatic void build_expect();
    int r = 0;
    int mag, s, v;
    exp_q.delete();
    exp_q.push_back(sym(1'b1, blk[0], 0, 0, 0));
    for (int i = 1; i < 64; i++) begin
      if (blk[i] == 0) begin
        r++;
      end else begin
        while (r >= 16) begin
          exp_q.push_back(sym(1'b0, 0, 15, 0, 0));
          r -= 16;
        end
        mag = (blk[i] < 0) ? -blk[i] : blk[i];
        s = 0;
        while ((1 << s) <= mag) s++;
        v = (blk[i] > 0) ? blk[i] : ((blk[i] - 1) & ((1 << s) - 1));
        exp_q.push_back(sym(1'b0, 0, r, s, v));
        r = 0;
      end
    end
    if (r > 0) exp_q.push_back(sym(1'b0, 0, 0, 0, 0));
  endfunction

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic random_blk(input int density);
    for (int i = 0; i < 64; i++)
      blk[i] = ($urandom_range(0, 99) < density) ? $urandom_range(0, 2046) - 1023 : 0;
    blk[0] = $urandom_range(0, 2046) - 1023;
  endtask

  // mode 0: rdy_in always 1; 1: random; 2: every symbol stalled for 5 cycles.
  task automatic run_block(input bit last, input int mode);
    int k = 0, cyc = 0, bd = 0, fl = 0, pend = 0, tail = 0;
    bit stall_prev = 1'b0, done = 1'b0;
    logic [29:0] prev = '0;
    logic [29:0] e;
    build_expect();
    while (!done && cyc < 3000) begin
      if (stall_prev) begin
        check("hold_valid", ena_out, 1);
        check("hold_outputs", {dc, in_dc, run, size, in}, prev);
      end
      if (ena_out) check("rdy_out_busy", rdy_out, 0);
      if (block_done) bd++;
      if (flush) begin
        fl++;
        check("flush_no_symbol", ena_out, 0);
      end
      pend = ena_out ? pend + 1 : 0;
      ena_in     = (k < 64) && ($urandom_range(0, 3) != 0);
      coef       = 11'(blk[(k < 64) ? k : 0]);
      last_block = (k == 0) ? last : 1'($urandom_range(0, 1));
      case (mode)
        0:       rdy_in = 1'b1;
        1:       rdy_in = 1'($urandom_range(0, 1));
        default: rdy_in = ena_out ? (pend > 5) : 1'b1;
      endcase
      if (ena_in && rdy_out) k++;
      if (ena_out && rdy_in) begin
        check("symbol_available", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("symbol", obs_sym(), e);
        end
      end
      stall_prev = ena_out && !rdy_in;
      prev = {dc, in_dc, run, size, in};
      if (k == 64 && exp_q.size() == 0 && bd > 0 && (fl > 0 || !last)) tail++;
      done = (tail > 4);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    ena_in = 1'b0;
    check("block_timeout", 64'(done), 1);
    check("symbols_left", 64'(exp_q.size()), 0);
    check("block_done_count", 64'(bd), 1);
    check("flush_count", 64'(fl), 64'(last));
    check("idle_after_block", ena_out, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {ena_out, flush, block_done, dc, in_dc, run, size, in}, 0);
  endtask

  initial begin
    rst = 1'b1; ena_in = 1'b0; rdy_in = 1'b0; coef = '0; last_block = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rdy_out_after_reset", rdy_out, 1);

    // DC only, all AC zero
    clear_blk(); blk[0] = -5;
    run_block(1'b0, 0);
    // two small AC values
    clear_blk(); blk[0] = 7; blk[1] = 3; blk[2] = -3;
    run_block(1'b0, 0);
    // one ZRL before a run of 4
    clear_blk(); blk[0] = 100; blk[21] = 1;
    run_block(1'b0, 1);
    // three ZRLs then size-10 symbol on the final coefficient
    clear_blk(); blk[0] = 0; blk[63] = -1023;
    run_block(1'b0, 2);
    // stalled coder over a mixed block
    clear_blk(); blk[0] = 1023; blk[1] = -1; blk[5] = 512; blk[40] = -2; blk[62] = 9;
    run_block(1'b0, 2);
    // final block of image, all zero
    clear_blk();
    run_block(1'b1, 1);

    // reset in the middle of a last block: no symbol, done or flush afterwards
    random_blk(30);
    rdy_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ena_in = 1'b1; coef = 11'(blk[i]); last_block = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    ena_in = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("midblock_reset_outputs");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      check("post_reset_quiet", {ena_out, flush, block_done, rdy_out}, 4'b0001);
    end

    for (int b = 0; b < 20; b++) begin
      random_blk($urandom_range(2, 40));
      run_block(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
